// File: rtl/mips_pkg.sv
// Shared MIPS multicycle core definitions used by the multiply/divide unit.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_t;

    localparam int          MD_ITER     = 32;
    localparam logic [31:0] MD_DZERO_LO = 32'hFFFFFFFF;

endpackage

// File: rtl/md_restore_step.sv
// One restoring-divide iteration: shift the next dividend bit into the remainder,
// trial-subtract the divisor, and keep the difference only if it stayed non-negative.
module md_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] rem_in,
    input  logic           next_bit,
    input  logic [WIDTH:0] divisor,
    output logic [WIDTH:0] rem_out,
    output logic           q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_in, next_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply / restoring divide unit driving HI/LO.
// Optional feature: define MULTDIV_DZERO_EXC_EN to abort divide-by-zero with a div_zero pulse.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   mag_a;
    logic [WIDTH:0]   mag_b;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             sign_a;
    logic             sign_b;
    logic             is_div;
    logic             dz_flag;

    logic [WIDTH:0]     abs_a;
    logic [WIDTH:0]     abs_b;
    logic [WIDTH+1:0]   mul_sum;
    logic [WIDTH:0]     div_rem;
    logic               div_q_bit;
    logic               neg;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_back;

    // Magnitudes are one bit wider so that |most negative| is represented exactly.
    assign abs_a = a[WIDTH-1] ? (WIDTH+1)'(0) - {a[WIDTH-1], a} : {1'b0, a};
    assign abs_b = b[WIDTH-1] ? (WIDTH+1)'(0) - {b[WIDTH-1], b} : {1'b0, b};

    assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_a : (WIDTH+1)'(0))};

    md_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (acc_hi),
        .next_bit (acc_lo[WIDTH-1]),
        .divisor  (mag_b),
        .rem_out  (div_rem),
        .q_bit    (div_q_bit)
    );

    assign neg      = sign_a ^ sign_b;
    assign prod_mag = {acc_hi[WIDTH-1:0], acc_lo};
    assign prod_fix = neg ? -prod_mag : prod_mag;
    assign quot_fix = neg ? -acc_lo : acc_lo;
    assign rem_fix  = sign_a ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    assign a_back   = sign_a ? -mag_a[WIDTH-1:0] : mag_a[WIDTH-1:0];

    // acc_hi/acc_lo double as product accumulator or remainder/quotient pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            is_div  <= 1'b0;
            dz_flag <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    dz_flag <= 1'b0;
                    if (mult_start || div_start) begin
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
                        is_div <= !mult_start;
                        acc_hi <= '0;
                        acc_lo <= mult_start ? abs_b[WIDTH-1:0] : abs_a[WIDTH-1:0];
                        if (mult_start) begin
                            state <= MULT;
`ifdef MULTDIV_DZERO_EXC_EN
                        end else if (b == '0) begin
                            dz_flag <= 1'b1;
                            state   <= DONE;
`endif
                        end else begin
                            dz_flag <= (b == '0);
                            state   <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc_hi <= mul_sum[WIDTH+1:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= FIX;
                end
                DIV: begin
                    acc_hi <= div_rem;
                    acc_lo <= {acc_lo[WIDTH-2:0], div_q_bit};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (dz_flag) begin
                        hi <= a_back;
                        lo <= WIDTH'(MD_DZERO_LO);
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef MULTDIV_DZERO_EXC_EN
    assign div_zero = (state == DONE) && dz_flag;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus hand-written abort/ignore sequences.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        string       name;
        logic        ms;
        logic        ds;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          lat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sbQ[$];
    int          nVectors     = 0;
    int          nMiscompares = 0;
    int          startCyc     = 0;
    logic [31:0] lastHi       = '0;
    logic [31:0] lastLo       = '0;

    function automatic vec_t mkVec(input string n, input logic ms, input logic ds,
                                   input logic [31:0] av, input logic [31:0] bv,
                                   input logic [31:0] eh, input logic [31:0] el,
                                   input logic ez, input int lat);
        vec_t v;
        v.name = n; v.ms = ms; v.ds = ds; v.av = av; v.bv = bv;
        v.eh = eh; v.el = el; v.ez = ez; v.lat = lat;
        return v;
    endfunction

    // Reference arithmetic: SV longint division truncates toward zero, remainder follows dividend.
    function automatic void refModel(input logic isDiv, input logic [31:0] av, input logic [31:0] bv,
                                     output logic [31:0] rh, output logic [31:0] rl);
        longint sa = longint'(signed'(av));
        longint sb = longint'(signed'(bv));
        longint p;
        longint q;
        longint r;
        if (!isDiv) begin
            p  = sa * sb;
            rh = p[63:32];
            rl = p[31:0];
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rh = r[31:0];
            rl = q[31:0];
        end
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveStart(input logic ms, input logic ds, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a          = av;
        b          = bv;
        mult_start = ms;
        div_start  = ds;
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        startCyc   = cyc;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        e.name = v.name; e.eh = v.eh; e.el = v.el; e.ez = v.ez; e.lat = v.lat;
        sbQ.push_back(e);
        driveStart(v.ms, v.ds, v.av, v.bv);
    endtask

    task automatic checkOutput();
        int   n = 0;
        bit   seenDone = 1'b0;
        bit   busyOk = 1'b1;
        bit   heldOk = 1'b1;
        exp_t e;
        for (int i = 0; i < 100; i++) begin
            n = cyc - startCyc + 1;
            if (done === 1'b1) begin
                seenDone = 1'b1;
                break;
            end
            if (busy !== 1'b1) busyOk = 1'b0;
            if (hi !== lastHi || lo !== lastLo) heldOk = 1'b0;
            @(negedge clk);
        end
        if (sbQ.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL scoreboard_empty: got done expected no result");
            return;
        end
        e = sbQ.pop_front();
        compare({e.name, "_busy_running"}, {31'b0, busyOk}, 32'd1);
        compare({e.name, "_hilo_held"}, {31'b0, heldOk}, 32'd1);
        if (!seenDone) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL %s_done_timeout: got no done expected done at %0d", e.name, e.lat);
        end else begin
            compare({e.name, "_latency"}, 32'(n), 32'(e.lat));
            compare({e.name, "_hi"}, hi, e.eh);
            compare({e.name, "_lo"}, lo, e.el);
            compare({e.name, "_div_zero"}, {31'b0, div_zero}, {31'b0, e.ez});
            compare({e.name, "_busy_at_done"}, {31'b0, busy}, 32'd1);
        end
        lastHi = e.eh;
        lastLo = e.el;
        @(negedge clk);
        compare({e.name, "_done_pulse"}, {31'b0, done}, 32'd0);
        compare({e.name, "_idle_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;
        int          extra;

        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = '0;
        b          = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        compare("reset_busy", {31'b0, busy}, 32'd0);
        compare("reset_done", {31'b0, done}, 32'd0);
        compare("reset_div_zero", {31'b0, div_zero}, 32'd0);
        compare("reset_hi", hi, 32'd0);
        compare("reset_lo", lo, 32'd0);

        vecs.push_back(mkVec("mul_7_m3", 1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34));
        vecs.push_back(mkVec("div_m7_2", 0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34));
        vecs.push_back(mkVec("div_ovf", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 34));
        vecs.push_back(mkVec("mul_min_min", 1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 34));
        vecs.push_back(mkVec("both_start", 1, 1, 32'd5, 32'd6, 32'h00000000, 32'h0000001E, 0, 34));
        vecs.push_back(mkVec("div_100_m7", 0, 1, 32'd100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 0, 34));
        vecs.push_back(mkVec("div_m100_m7", 0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 0, 34));
`ifdef MULTDIV_DZERO_EXC_EN
        vecs.push_back(mkVec("div0_pos", 0, 1, 32'h12345678, 32'd0, 32'hFFFFFFFE, 32'h0000000E, 1, 1));
        vecs.push_back(mkVec("div0_neg", 0, 1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFE, 32'h0000000E, 1, 1));
`else
        vecs.push_back(mkVec("div0_pos", 0, 1, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 0, 34));
        vecs.push_back(mkVec("div0_neg", 0, 1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0, 34));
`endif
        vecs.push_back(mkVec("mul_m1_m1", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 34));
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i % 2 == 1) ? ((i == 3) ? 32'($urandom_range(1, 1000)) : $urandom) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            refModel(i % 2 == 1, ra, rb, eh, el);
            vecs.push_back(mkVec($sformatf("rand%0d", i), i % 2 == 0, i % 2 == 1, ra, rb, eh, el, 0, 34));
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // A divide request arriving mid-multiply must be dropped; operands change too.
        refModel(1'b0, 32'd9, 32'hFFFFFFFE, eh, el);
        sbQ.push_back('{name: "mul_ignore_div", eh: eh, el: el, ez: 1'b0, lat: 34});
        driveStart(1'b1, 1'b0, 32'd9, 32'hFFFFFFFE);
        repeat (9) @(negedge clk);
        a         = 32'd100;
        b         = 32'd3;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        checkOutput();
        extra = 0;
        repeat (40) begin
            if (done === 1'b1) extra++;
            @(negedge clk);
        end
        compare("ignored_div_no_done", 32'(extra), 32'd0);

        // Reset in the middle of a divide aborts without a done pulse.
        driveStart(1'b0, 1'b1, 32'd1000, 32'd7);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compare("abort_busy", {31'b0, busy}, 32'd0);
        compare("abort_done", {31'b0, done}, 32'd0);
        compare("abort_div_zero", {31'b0, div_zero}, 32'd0);
        compare("abort_hi", hi, 32'd0);
        compare("abort_lo", lo, 32'd0);
        lastHi = '0;
        lastLo = '0;
        extra  = 0;
        repeat (40) begin
            if (done === 1'b1) extra++;
            @(negedge clk);
        end
        compare("abort_no_done", 32'(extra), 32'd0);

        applyStimulus(mkVec("post_reset_mul", 1, 0, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFD6, 0, 34));
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide responder for the MIPS multicycle core. It accepts one-cycle start pulses from the control unit, runs a 32-iteration shift-add multiply or restoring divide, and returns a one-cycle `done` pulse. It drives the HI/LO result pair consumed by MFHI/MFLO and the datapath `Hi_src`/`Lo_src` muxes. Operand A comes from register A and operand B from register B, both latched by the datapath.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `mult_start`  in  1  one-cycle pulse; begin signed A×B
- `div_start`  in  1  one-cycle pulse; begin signed A÷B
- `a`  in  WIDTH  multiplicand / dividend, sampled on the start edge
- `b`  in  WIDTH  multiplier / divisor, sampled on the start edge
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid from this cycle on
- `hi`  out  WIDTH  product[63:32] or remainder
- `lo`  out  WIDTH  product[31:0] or quotient
- `div_zero`  out  1  one-cycle pulse with `done` when divisor was 0 (see Configuration)

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - `mult_start` → MULT.
  - Else `div_start` → DIV. `mult_start` has priority when both are high; `div_start` is then dropped.
  - Both starts load |a|, |b| and their sign bits, and clear the counter.
- Starts are ignored outside IDLE. No queueing.
- MULT: 32 shift-add iterations on the 64-bit magnitude accumulator, one per cycle. The counter counts 0..31, then → FIX.
- DIV: 32 restoring iterations on magnitudes, one per cycle. Each iteration shifts the remainder left, subtracts the divisor, and restores if the result is negative. The counter counts 0..31, then → FIX.
- FIX, one cycle, applies signs:
  - Product is negated if sign(a)^sign(b).
  - Quotient is negated if sign(a)^sign(b), truncating toward zero.
  - Remainder takes the sign of a.
  - The result is written to `hi`/`lo`. → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Arithmetic rules:
  - Magnitudes use WIDTH+1 bits internally, so |−2^31| is exact.
  - Overflow case −2^31 ÷ −1 yields `lo`=0x80000000 and `hi`=0 (wrap), with no flag.
- `hi`/`lo` hold the last result until the next FIX (or zero-divide abort). They never show partial values.
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Reset mid-operation aborts immediately. The next cycle is IDLE with all outputs at reset values, and no `done` is issued.

## Timing
- Start is sampled at edge k. `busy`=1 from cycle k+1 through the `done` cycle inclusive.
- MULT: 32 iteration cycles + FIX + DONE. `done` is high in cycle k+34.
- DIV: same schedule, `done` high in cycle k+34.
- A new start is accepted in the cycle after `done` (IDLE). Back-to-back issue rate is one operation per 35 cycles.
- `done` and `div_zero` are registered, never combinational from inputs.

## Configuration
- `MULTDIV_DZERO_EXC_EN` defined:
  - A divisor of 0 is detected on the `div_start` edge. The unit goes IDLE→DONE directly: `done` and `div_zero` are high in cycle k+1.
  - `hi`/`lo` are unchanged.
  - The control unit uses `div_zero` to raise the divide-by-zero exception.
- Not defined:
  - `div_zero` is tied 0.
  - Divide by zero runs the full schedule (`done` at k+34) with forced result `hi`=a, `lo`=0xFFFFFFFF.

## Structure
- Shared package `mips_pkg`:
  - `md_state_t` enum (IDLE, MULT, DIV, FIX, DONE).
  - `MD_ITER` = 32.
  - `MD_DZERO_LO` = 32'hFFFFFFFF.
- One sub-module, `md_restore_step`: combinational single restoring-divide iteration (remainder in, divisor, quotient bit out). It is instantiated once in the DIV path.

## Test plan
- `mult_start`, a=7, b=−3 → `done` at k+34 with `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy` high k+1..k+34.
- `div_start`, a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Also a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- `mult_start`, a=b=0x80000000 → `hi`=0x40000000, `lo`=0. Same-cycle `mult_start`+`div_start` → multiply result only.
- `div_start`, b=0: with the macro, `done`+`div_zero` at k+1 and hi/lo unchanged. Without it, `done` at k+34, `hi`=a, `lo`=0xFFFFFFFF, `div_zero`=0.
- `div_start` pulsed at cycle k+10 of a running multiply → ignored, only one `done`. `reset` at k+20 → no `done`, hi/lo=0, next start accepted normally.
